// File: rtl/bsg_nonsynth_wormhole_test_mem_lat_pkg.sv
// Shared definitions for the wormhole test memory.
// Contents: wormhole cache opcodes, address-hash mode encodings, FSM state
// encodings and a clog2 helper that never returns zero.
package bsg_nonsynth_wormhole_test_mem_lat_pkg;

  typedef enum logic [1:0] {
    e_wh_read             = 2'b00,
    e_wh_write_non_masked = 2'b01,
    e_wh_write_masked     = 2'b10
  } wh_opcode_e;

  localparam int wh_opcode_width_gp = 2;

  // Address hash modes selected by concentration_p.
  localparam int hash_per_cid_gp       = 0;
  localparam int hash_concentrated_gp  = 1;

  localparam logic [3:0] s_reset     = 4'd0;
  localparam logic [3:0] s_ready     = 4'd1;
  localparam logic [3:0] s_recv_addr = 4'd2;
  localparam logic [3:0] s_recv_mask = 4'd3;
  localparam logic [3:0] s_recv_data = 4'd4;
  localparam logic [3:0] s_wait_lat  = 4'd5;
  localparam logic [3:0] s_send_hdr  = 4'd6;
  localparam logic [3:0] s_send_data = 4'd7;
  localparam logic [3:0] s_drain     = 4'd8;

  // Counter widths must stay at least one bit even when the count range is 1.
  function automatic int safe_clog2(int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/bsg_nonsynth_wormhole_test_mem_lat_array.sv
// Storage array for the wormhole test memory.
// Ports:
//   clk     clock
//   w_v     write enable
//   w_addr  write element index
//   w_mask  per-lane write enable (one bit per lane_width_p lane)
//   w_data  write data
//   r_addr  read element index
//   r_data  combinational read data, unknown bits forced to 0
module bsg_nonsynth_wormhole_test_mem_lat_array #(
  parameter int lane_width_p = 32,
  parameter int lanes_p      = 2,
  parameter int els_p        = 16,
  parameter int addr_width_p = 4
) (
  input  logic                            clk,
  input  logic                            w_v,
  input  logic [addr_width_p-1:0]         w_addr,
  input  logic [lanes_p-1:0]              w_mask,
  input  logic [lanes_p*lane_width_p-1:0] w_data,
  input  logic [addr_width_p-1:0]         r_addr,
  output logic [lanes_p*lane_width_p-1:0] r_data
);

  logic [lanes_p*lane_width_p-1:0] mem [els_p];
  logic [lanes_p*lane_width_p-1:0] r_word;

  // Contents are intentionally not reset: a reset mid-test keeps data.
  always_ff @(posedge clk) begin
    if (w_v) begin
      for (int i = 0; i < lanes_p; i++) begin
        if (w_mask[i]) begin
          mem[w_addr][i*lane_width_p +: lane_width_p] <= w_data[i*lane_width_p +: lane_width_p];
        end
      end
    end
  end

  assign r_word = mem[r_addr];

  // Never-written locations would otherwise leak X into the network.
  for (genvar gi = 0; gi < lanes_p*lane_width_p; gi++) begin : g_xfilter
    assign r_data[gi] = (r_word[gi] === 1'b1);
  end

endmodule

// File: rtl/bsg_nonsynth_wormhole_test_mem_lat.sv
// Wormhole test memory backing one or more vcaches over one ready/valid link.
// Serves block reads (with programmable fill latency) and masked/non-masked
// block writes; drains illegal requests and flags them stickily.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   wh_link_sif_i    incoming link {v, ready_and_rev, data}
//   wh_link_sif_o    outgoing link {v, ready_and_rev, data}
//   num_reads_o      completed fill responses (saturating)
//   num_writes_o     completed evict writes (saturating)
//   err_o            sticky illegal-opcode flag
module bsg_nonsynth_wormhole_test_mem_lat
  import bsg_nonsynth_wormhole_test_mem_lat_pkg::*;
#(
  parameter int vcache_data_width_p          = 32,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int vcache_dma_data_width_p      = 64,
  parameter int num_vcaches_p                = 16,
  parameter int wh_flit_width_p              = 64,
  parameter int wh_cid_width_p               = 2,
  parameter int wh_cord_width_p              = 7,
  parameter int wh_len_width_p               = 4,
  parameter int mem_size_p                   = 2**20,
  parameter int concentration_p              = 0,
  parameter int fill_latency_p               = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [wh_flit_width_p+1:0] wh_link_sif_i,
  output logic [wh_flit_width_p+1:0] wh_link_sif_o,
  output logic [31:0]                num_reads_o,
  output logic [31:0]                num_writes_o,
  output logic                       err_o
);

  localparam int dma_ratio_lp          = vcache_dma_data_width_p / vcache_data_width_p;
  localparam int data_len_lp           = vcache_block_size_in_words_p / dma_ratio_lp;
  localparam int mem_els_lp            = mem_size_p / (vcache_dma_data_width_p / 8);
  localparam int mem_addr_width_lp     = safe_clog2(mem_els_lp);
  localparam int block_offset_width_lp = safe_clog2(vcache_block_size_in_words_p * (vcache_data_width_p / 8));
  localparam int count_width_lp        = safe_clog2(data_len_lp);
  localparam int lat_width_lp          = safe_clog2(fill_latency_p + 1);
  localparam int lg_num_vcaches_lp     = safe_clog2(num_vcaches_p);
  localparam int hash_slice_width_lp   = mem_addr_width_lp - lg_num_vcaches_lp - count_width_lp
                                         - ((concentration_p == hash_per_cid_gp) ? wh_cid_width_p : 0);

  // Header flit field offsets, LSB first: cord, len, cid, src_cord, src_cid, opcode.
  localparam int cord_lo_lp     = 0;
  localparam int len_lo_lp      = cord_lo_lp + wh_cord_width_p;
  localparam int cid_lo_lp      = len_lo_lp + wh_len_width_p;
  localparam int src_cord_lo_lp = cid_lo_lp + wh_cid_width_p;
  localparam int src_cid_lo_lp  = src_cord_lo_lp + wh_cord_width_p;
  localparam int opcode_lo_lp   = src_cid_lo_lp + wh_cid_width_p;

  localparam logic [count_width_lp-1:0] count_last_lp = count_width_lp'(data_len_lp - 1);
  localparam logic [lat_width_lp-1:0]   lat_last_lp   = lat_width_lp'(fill_latency_p - 1);

  if (vcache_dma_data_width_p != wh_flit_width_p) begin : g_bad_dma_width
    $error("vcache_dma_data_width_p must equal wh_flit_width_p");
  end
  if (data_len_lp < 1) begin : g_bad_data_len
    $error("block must hold at least one dma beat");
  end
  if (hash_slice_width_lp < 1) begin : g_bad_hash_width
    $error("memory too small for the address hash");
  end

  logic                       in_v;
  logic                       in_ready;
  logic [wh_flit_width_p-1:0] in_data;
  logic                       unused_link;

  assign in_v        = wh_link_sif_i[wh_flit_width_p+1];
  assign in_ready    = wh_link_sif_i[wh_flit_width_p];
  assign in_data     = wh_link_sif_i[wh_flit_width_p-1:0];
  assign unused_link = ^wh_link_sif_i;

  logic [3:0]                              state_r;
  logic [wh_opcode_width_gp-1:0]           opcode_r;
  logic [wh_cord_width_p-1:0]              src_cord_r;
  logic [wh_cid_width_p-1:0]               src_cid_r;
  logic [wh_len_width_p-1:0]               len_r;
  logic [wh_len_width_p-1:0]               drain_r;
  logic [hash_slice_width_lp-1:0]          addr_r;
  logic [vcache_block_size_in_words_p-1:0] mask_r;
  logic [count_width_lp-1:0]               count_lo_r;
  logic [lat_width_lp-1:0]                 lat_r;
  logic [31:0]                             num_reads_r;
  logic [31:0]                             num_writes_r;
  logic                                    err_r;

  // Beats of one block sit at consecutive elements.
  logic [mem_addr_width_lp-1:0] mem_addr;
  if (concentration_p == hash_concentrated_gp) begin : g_hash_conc
    assign mem_addr = {src_cord_r[lg_num_vcaches_lp-1:0], addr_r, count_lo_r};
  end else begin : g_hash_cid
    assign mem_addr = {src_cid_r, src_cord_r[lg_num_vcaches_lp-1:0], addr_r, count_lo_r};
  end

  logic                            w_v;
  logic [dma_ratio_lp-1:0]         lane_mask;
  logic [vcache_dma_data_width_p-1:0] rd_data;

  assign w_v       = (state_r == s_recv_data) && in_v;
  assign lane_mask = dma_ratio_lp'(mask_r >> (32'(count_lo_r) * dma_ratio_lp));

  bsg_nonsynth_wormhole_test_mem_lat_array #(
    .lane_width_p (vcache_data_width_p),
    .lanes_p      (dma_ratio_lp),
    .els_p        (mem_els_lp),
    .addr_width_p (mem_addr_width_lp)
  ) mem_array (
    .clk    (clk_i),
    .w_v    (w_v),
    .w_addr (mem_addr),
    .w_mask (lane_mask),
    .w_data (in_data),
    .r_addr (mem_addr),
    .r_data (rd_data)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= s_reset;
      opcode_r     <= '0;
      src_cord_r   <= '0;
      src_cid_r    <= '0;
      len_r        <= '0;
      drain_r      <= '0;
      addr_r       <= '0;
      mask_r       <= '0;
      count_lo_r   <= '0;
      lat_r        <= '0;
      num_reads_r  <= '0;
      num_writes_r <= '0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        s_reset: state_r <= s_ready;
        s_ready: if (in_v) begin
          opcode_r   <= in_data[opcode_lo_lp +: wh_opcode_width_gp];
          src_cord_r <= in_data[src_cord_lo_lp +: wh_cord_width_p];
          src_cid_r  <= in_data[src_cid_lo_lp +: wh_cid_width_p];
          len_r      <= in_data[len_lo_lp +: wh_len_width_p];
          state_r    <= s_recv_addr;
        end
        s_recv_addr: if (in_v) begin
          addr_r <= in_data[block_offset_width_lp +: hash_slice_width_lp];
          case (opcode_r)
            e_wh_read:             state_r <= (fill_latency_p > 0) ? s_wait_lat : s_send_hdr;
            e_wh_write_non_masked: begin mask_r <= '1; state_r <= s_recv_data; end
            e_wh_write_masked:     state_r <= s_recv_mask;
            default: begin
              // The addr flit was the first of len flits; swallow the rest.
              err_r <= 1'b1;
              if (len_r > wh_len_width_p'(1)) begin
                drain_r <= len_r - 1'b1;
                state_r <= s_drain;
              end else begin
                state_r <= s_ready;
              end
            end
          endcase
        end
        s_recv_mask: if (in_v) begin
          mask_r  <= in_data[vcache_block_size_in_words_p-1:0];
          state_r <= s_recv_data;
        end
        s_recv_data: if (in_v) begin
          if (count_lo_r == count_last_lp) begin
            count_lo_r   <= '0;
            num_writes_r <= (num_writes_r == '1) ? num_writes_r : num_writes_r + 32'd1;
            state_r      <= s_ready;
          end else begin
            count_lo_r <= count_lo_r + 1'b1;
          end
        end
        s_wait_lat: begin
          if (lat_r == lat_last_lp) begin
            lat_r   <= '0;
            state_r <= s_send_hdr;
          end else begin
            lat_r <= lat_r + 1'b1;
          end
        end
        s_send_hdr: if (in_ready) state_r <= s_send_data;
        s_send_data: if (in_ready) begin
          if (count_lo_r == count_last_lp) begin
            count_lo_r  <= '0;
            num_reads_r <= (num_reads_r == '1) ? num_reads_r : num_reads_r + 32'd1;
            state_r     <= s_ready;
          end else begin
            count_lo_r <= count_lo_r + 1'b1;
          end
        end
        s_drain: if (in_v) begin
          if (drain_r == wh_len_width_p'(1)) state_r <= s_ready;
          drain_r <= drain_r - 1'b1;
        end
        default: state_r <= s_ready;
      endcase
    end
  end

  // Outputs decode from state only, so an asynchronous reset clears them at once.
  logic                       out_v;
  logic                       out_ready;
  logic [wh_flit_width_p-1:0] out_data;

  assign out_v     = (state_r == s_send_hdr) || (state_r == s_send_data);
  assign out_ready = (state_r == s_ready) || (state_r == s_recv_addr) || (state_r == s_recv_mask)
                     || (state_r == s_recv_data) || (state_r == s_drain);

  always_comb begin
    out_data = '0;
    if (state_r == s_send_hdr) begin
      out_data[cord_lo_lp +: wh_cord_width_p] = src_cord_r;
      out_data[len_lo_lp +: wh_len_width_p]   = wh_len_width_p'(data_len_lp);
      out_data[cid_lo_lp +: wh_cid_width_p]   = src_cid_r;
    end else if (state_r == s_send_data) begin
      out_data = rd_data;
    end
  end

  assign wh_link_sif_o = {out_v, out_ready, out_data};
  assign num_reads_o   = num_reads_r;
  assign num_writes_o  = num_writes_r;
  assign err_o         = err_r;

endmodule

// File: tb/tb_bsg_nonsynth_wormhole_test_mem_lat.sv
// Directed bench: instance 0 uses per-cid hashing and no fill latency,
// instance 1 uses concentrated hashing and fill latency 5.
module tb_bsg_nonsynth_wormhole_test_mem_lat;

  logic        clk;
  logic        rst;
  logic        li_v    [2];
  logic        li_rdy  [2];
  logic [63:0] li_data [2];
  logic [65:0] link_in  [2];
  logic [65:0] link_out [2];
  logic [31:0] num_reads  [2];
  logic [31:0] num_writes [2];
  logic        err [2];

  int checks   = 0;
  int failures = 0;

  logic [63:0] got_hdr;
  logic [63:0] got [4];

  assign link_in[0] = {li_v[0], li_rdy[0], li_data[0]};
  assign link_in[1] = {li_v[1], li_rdy[1], li_data[1]};

  bsg_nonsynth_wormhole_test_mem_lat #(
    .fill_latency_p(0), .concentration_p(0)
  ) dut0 (
    .clk_i(clk), .reset_i(rst), .wh_link_sif_i(link_in[0]), .wh_link_sif_o(link_out[0]),
    .num_reads_o(num_reads[0]), .num_writes_o(num_writes[0]), .err_o(err[0])
  );

  bsg_nonsynth_wormhole_test_mem_lat #(
    .fill_latency_p(5), .concentration_p(1)
  ) dut1 (
    .clk_i(clk), .reset_i(rst), .wh_link_sif_i(link_in[1]), .wh_link_sif_o(link_out[1]),
    .num_reads_o(num_reads[1]), .num_writes_o(num_writes[1]), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request header: opcode[23:22] src_cid[21:20] src_cord[19:13] len[10:7].
  function automatic logic [63:0] hdr(logic [1:0] op, logic [6:0] scord, logic [1:0] scid, logic [3:0] len);
    logic [63:0] h;
    h = '0;
    h[22 +: 2] = op;
    h[20 +: 2] = scid;
    h[13 +: 7] = scord;
    h[7 +: 4]  = len;
    return h;
  endfunction

  // Fill header: cord[6:0], len=4 at [10:7], cid[12:11].
  function automatic logic [63:0] fill_hdr(logic [6:0] cord, logic [1:0] cid);
    logic [63:0] h;
    h = '0;
    h[6:0]   = cord;
    h[10:7]  = 4'd4;
    h[12:11] = cid;
    return h;
  endfunction

  task automatic send(int k, logic [63:0] d);
    bit done;
    done = 1'b0;
    li_v[k] = 1'b1;
    li_data[k] = d;
    for (int i = 0; i < 40 && !done; i++) begin
      if (link_out[k][64]) done = 1'b1;
      @(posedge clk); #1;
    end
    li_v[k] = 1'b0;
    li_data[k] = '0;
    check("send_ack", 64'(done), 64'd1);
  endtask

  task automatic recv(int k, output logic [63:0] d);
    bit got_v;
    got_v = 1'b0;
    d = '0;
    li_rdy[k] = 1'b1;
    for (int i = 0; i < 40 && !got_v; i++) begin
      if (link_out[k][65]) begin
        got_v = 1'b1;
        d = link_out[k][63:0];
      end
      @(posedge clk); #1;
    end
    check("recv_valid", 64'(got_v), 64'd1);
  endtask

  task automatic recv_block(int k);
    logic [63:0] t;
    recv(k, got_hdr);
    for (int i = 0; i < 4; i++) begin
      recv(k, t);
      got[i] = t;
    end
    $display("txn fill k=%0d hdr=%h d0=%h d3=%h", k, got_hdr, got[0], got[3]);
  endtask

  task automatic read_req(int k, logic [6:0] cord, logic [1:0] cid, logic [63:0] addr);
    send(k, hdr(2'd0, cord, cid, 4'd1));
    send(k, addr);
    $display("txn read_req k=%0d cord=%0d cid=%0d addr=%h", k, cord, cid, addr);
  endtask

  task automatic write_block(int k, bit masked, logic [6:0] cord, logic [1:0] cid, logic [63:0] addr,
                             logic [63:0] mask, logic [63:0] d0, logic [63:0] d1,
                             logic [63:0] d2, logic [63:0] d3);
    send(k, hdr(masked ? 2'd2 : 2'd1, cord, cid, masked ? 4'd6 : 4'd5));
    send(k, addr);
    if (masked) send(k, mask);
    send(k, d0);
    send(k, d1);
    send(k, d2);
    send(k, d3);
    $display("txn write k=%0d masked=%0d cord=%0d cid=%0d addr=%h", k, masked, cord, cid, addr);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    li_v[0] = 1'b0; li_v[1] = 1'b0;
    li_rdy[0] = 1'b1; li_rdy[1] = 1'b1;
    li_data[0] = '0; li_data[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl0", 64'(link_out[0][65:64]), 64'd0);
    check("rst_data0", link_out[0][63:0], 64'd0);
    check("rst_ctl1", 64'(link_out[1][65:64]), 64'd0);
    check("rst_reads0", 64'(num_reads[0]), 64'd0);
    check("rst_writes0", 64'(num_writes[0]), 64'd0);
    check("rst_err0", 64'(err[0]), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(link_out[0][64]), 64'd1);

    // Non-masked write then read of the same block.
    write_block(0, 1'b0, 7'd3, 2'd1, 64'h80, 64'hFF, 64'h1111111111111111, 64'h2222222222222222,
                64'h3333333333333333, 64'h4444444444444444);
    check("writes_1", 64'(num_writes[0]), 64'd1);
    read_req(0, 7'd3, 2'd1, 64'h80);
    check("lat0_hdr_v", 64'(link_out[0][65]), 64'd1);
    recv_block(0);
    check("rd1_hdr", got_hdr, fill_hdr(7'd3, 2'd1));
    check("rd1_d0", got[0], 64'h1111111111111111);
    check("rd1_d1", got[1], 64'h2222222222222222);
    check("rd1_d2", got[2], 64'h3333333333333333);
    check("rd1_d3", got[3], 64'h4444444444444444);
    check("reads_1", 64'(num_reads[0]), 64'd1);

    // Same cord/addr with another cid maps elsewhere (never written -> 0).
    read_req(0, 7'd3, 2'd0, 64'h80);
    recv_block(0);
    check("cid0_hdr", got_hdr, fill_hdr(7'd3, 2'd0));
    check("cid0_d0", got[0], 64'd0);
    check("cid0_d3", got[3], 64'd0);

    // Masked write: words 0-3 take 0x55.., words 4-7 keep 0xAA...
    write_block(0, 1'b0, 7'd3, 2'd1, 64'h100, 64'hFF, {4{16'hAAAA}}, {4{16'hAAAA}},
                {4{16'hAAAA}}, {4{16'hAAAA}});
    write_block(0, 1'b1, 7'd3, 2'd1, 64'h100, 64'h0F, {4{16'h5555}}, {4{16'h5555}},
                {4{16'h5555}}, {4{16'h5555}});
    check("writes_3", 64'(num_writes[0]), 64'd3);
    read_req(0, 7'd3, 2'd1, 64'h100);
    recv_block(0);
    check("mask_d0", got[0], {4{16'h5555}});
    check("mask_d1", got[1], {4{16'h5555}});
    check("mask_d2", got[2], {4{16'hAAAA}});
    check("mask_d3", got[3], {4{16'hAAAA}});

    // Backpressure on beat 2.
    read_req(0, 7'd3, 2'd1, 64'h80);
    recv(0, got_hdr);
    recv(0, got[0]);
    recv(0, got[1]);
    li_rdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_v", 64'(link_out[0][65]), 64'd1);
      check("stall_data", link_out[0][63:0], 64'h3333333333333333);
      @(posedge clk); #1;
    end
    recv(0, got[2]);
    recv(0, got[3]);
    check("bp_d1", got[1], 64'h2222222222222222);
    check("bp_d2", got[2], 64'h3333333333333333);
    check("bp_d3", got[3], 64'h4444444444444444);
    check("bp_idle_v", 64'(link_out[0][65]), 64'd0);
    check("reads_4", 64'(num_reads[0]), 64'd4);

    // Illegal opcode, len=3: addr + two flits drained. The last drained flit
    // looks like a write header so a short drain would corrupt what follows.
    send(0, hdr(2'd3, 7'd3, 2'd1, 4'd3));
    send(0, 64'h80);
    send(0, 64'hDEADBEEF);
    send(0, hdr(2'd1, 7'd3, 2'd1, 4'd5));
    $display("txn illegal k=0 len=3");
    check("err_set", 64'(err[0]), 64'd1);
    read_req(0, 7'd3, 2'd1, 64'h80);
    recv_block(0);
    check("post_err_hdr", got_hdr, fill_hdr(7'd3, 2'd1));
    check("post_err_d0", got[0], 64'h1111111111111111);
    check("post_err_d3", got[3], 64'h4444444444444444);
    check("err_sticky", 64'(err[0]), 64'd1);

    // Asynchronous reset in the middle of a fill.
    read_req(0, 7'd3, 2'd1, 64'h80);
    recv(0, got_hdr);
    recv(0, got[0]);
    li_rdy[0] = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("arst_ctl", 64'(link_out[0][65:64]), 64'd0);
    check("arst_reads", 64'(num_reads[0]), 64'd0);
    check("arst_writes", 64'(num_writes[0]), 64'd0);
    check("arst_err", 64'(err[0]), 64'd0);
    $display("txn async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    read_req(0, 7'd3, 2'd1, 64'h80);
    recv_block(0);
    check("arst_rd_d0", got[0], 64'h1111111111111111);
    check("arst_rd_d3", got[3], 64'h4444444444444444);
    check("arst_reads_1", 64'(num_reads[0]), 64'd1);

    // Instance 1: fill latency 5 and concentrated hashing (cid 0 and 2 alias).
    write_block(1, 1'b0, 7'd2, 2'd0, 64'h40, 64'hFF, {8{8'hA0}}, {8{8'hB0}}, {8{8'hC0}}, {8{8'hD0}});
    check("i1_writes", 64'(num_writes[1]), 64'd1);
    read_req(1, 7'd2, 2'd2, 64'h40);
    n = 0;
    while (!link_out[1][65] && n < 20) begin
      check("wait_rdy", 64'(link_out[1][64]), 64'd0);
      @(posedge clk); #1;
      n++;
    end
    check("fill_latency", 64'(n + 1), 64'd6);
    recv_block(1);
    check("i1_hdr", got_hdr, fill_hdr(7'd2, 2'd2));
    check("i1_d0", got[0], {8{8'hA0}});
    check("i1_d1", got[1], {8{8'hB0}});
    check("i1_d2", got[2], {8{8'hC0}});
    check("i1_d3", got[3], {8{8'hD0}});
    check("i1_reads", 64'(num_reads[1]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
